wbm_arb2: RTL and testbench
===========================

Name: wbm_arb2

Overview:
- Two-master Wishbone arbiter/scheduler that shares one WB master port between the SPI-slave bridge (m0) and a second host bridge, e.g. the UART master (m1).
- Sits between the bridges' WB master outputs and the system interconnect.
- Round-robin grant, with the grant held for the whole cyc window.
- Optional watchdog that ends a transfer the slave never acknowledges.

Parameters:
- AW, 32, address width.
- DW, 32, data width; sel width = DW/8.
- TO_CYCLES, 1024, timeout limit in sys_clk cycles (only used with WBM_ARB_TIMEOUT_EN); must be at least 2.

Ports:
- sys_clk  input  1  system clock, single clock domain
- rst_n  input  1  asynchronous active-low reset
- mN_cyc_i  input  1  master N cycle, N=0,1
- mN_stb_i  input  1  master N strobe
- mN_adr_i  input  AW  master N address
- mN_we_i  input  1  master N write enable
- mN_dat_i  input  DW  master N write data
- mN_sel_i  input  DW/8  master N byte enables
- mN_dat_o  output  DW  read data to master N
- mN_ack_o  output  1  ack to master N
- mN_err_o  output  1  error to master N
- s_cyc_o, s_stb_o, s_we_o  output  1 each  shared port control
- s_adr_o  output  AW  shared port address
- s_dat_o  output  DW  shared port write data
- s_sel_o  output  DW/8  shared port byte enables
- s_dat_i  input  DW  shared port read data
- s_ack_i, s_err_i  input  1 each  shared port response
- gnt_o  output  2  one-hot current grant; 00 = idle
- to_evt_o  output  1  one-cycle timeout pulse

Behaviour:
- State machine states:
  - IDLE, GNT0, GNT1 always present.
  - TOUT present only with WBM_ARB_TIMEOUT_EN.
  - All state is registered on sys_clk.
  - On rst_n low: state=IDLE, last_gnt=1 (so m0 wins the first contention), timeout counter=0.
- IDLE:
  - Only m0_cyc_i high -> GNT0.
  - Only m1_cyc_i high -> GNT1.
  - Both high -> grant the master that is not last_gnt.
  - Transition on the next clock edge: 1 cycle grant latency.
  - last_gnt updates on entry to GNTn.
- GNTn:
  - Held while mN_cyc_i=1; multiple stb/ack transfers are allowed inside one grant.
  - mN_cyc_i=0 -> IDLE. There is always at least 1 IDLE cycle between grants, so no back-to-back handoff.
  - A request from the other master is never preempted.
- Output muxing (combinational from state):
  - s_cyc_o = granted mN_cyc_i; s_stb_o = granted mN_stb_i; adr/we/dat/sel come from the granted master.
  - In IDLE all s_* outputs = 0.
  - mN_ack_o = s_ack_i and mN_err_o = s_err_i, only for the granted master; 0 for the other.
  - mN_dat_o = s_dat_i broadcast to both masters; valid only with ack.
  - gnt_o: IDLE=00, GNT0=01, GNT1=10.
- Simultaneous events:
  - mN_cyc_i dropping in the same cycle as s_ack_i: the ack still passes through, then -> IDLE.
  - Ack and err together are both forwarded; the master treats the transfer as an error.
- Reset mid-transfer: all outputs drop to 0 immediately (asynchronous); in-flight transfer is abandoned.
- to_evt_o = 0 when the timeout feature is excluded.

Optional Feature:
- Macro: WBM_ARB_TIMEOUT_EN.
- Defined:
  - Counter width is clog2(TO_CYCLES+1).
  - Increments each cycle s_stb_o=1 and s_ack_i=0 and s_err_i=0.
  - Clears on ack, err, or leaving GNTn.
  - When count reaches TO_CYCLES-1 while still pending -> TOUT for exactly 1 cycle:
    - mN_err_o=1 to the owning master;
    - s_cyc_o = s_stb_o = 0;
    - to_evt_o=1;
    - counter cleared.
  - TOUT -> IDLE unconditionally; last_gnt is unchanged.
- Undefined: no counter, no TOUT state; a transfer waits forever; to_evt_o tied 0.

Test Plan:
- Reset then m0 single write (adr 0x3000_0010, dat 0xA5A5_5A5A, sel F); slave acks after 3 cycles:
  - gnt_o=01 one cycle after cyc;
  - s_* match m0;
  - m0_ack_o pulses once, m1_ack_o=0;
  - gnt_o=00 after cyc drops.
- m0 and m1 raise cyc in the same cycle after reset:
  - m0 granted first; m1 granted after m0 drops cyc plus 1 IDLE cycle.
  - Repeat with both requesting again: m0 granted first again, since last_gnt=1 after m1's grant (alternation).
- m1 holds cyc for 4 back-to-back reads (data 0x11..0x44) while m0 requests throughout:
  - m0 is not granted until m1 drops cyc;
  - m1_dat_o returns 0x11, 0x22, 0x33, 0x44 with acks.
- Slave returns s_err_i on an m0 read: m0_err_o=1 for that cycle, m1_err_o=0, grant released when m0 drops cyc.
- Timeout (macro defined, TO_CYCLES=8), slave never acks:
  - m0_err_o and to_evt_o pulse once, counted from the first s_stb_o cycle;
  - s_stb_o low in that pulse cycle;
  - next cycle gnt_o=00.
  - Macro undefined: no err, grant held indefinitely.
- rst_n asserted mid-transfer while granted to m1: s_cyc_o/s_stb_o and gnt_o go 0 immediately; after release m0 wins the next contention.

Source files
------------

// File: rtl/wbm_arb2.sv
// wbm_arb2: round-robin two-master Wishbone arbiter onto one shared port.
// Ports: sys_clk, rst_n; m0_*/m1_* master side; s_* shared port; gnt_o, to_evt_o.
// Optional macro WBM_ARB_TIMEOUT_EN adds a watchdog that errors unacked transfers.
module wbm_arb2 #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TO_CYCLES = 1024
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic            m0_we_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic            m1_we_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o,
  output logic            to_evt_o
);

  if (TO_CYCLES < 2) begin : g_bad_to
    $error("wbm_arb2: TO_CYCLES must be at least 2");
  end

`ifdef WBM_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {
    IDLE, GNT0, GNT1, TOUT
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, GNT0, GNT1
  } state_t;
`endif

  state_t state, state_nxt;
  logic   last_gnt, last_gnt_nxt;
  logic   to_hit;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

`ifdef WBM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          pend;
  logic          in_gnt;

  assign pend   = s_stb_o & ~s_ack_i & ~s_err_i;
  assign to_hit = pend & (cnt == CW'(TO_CYCLES - 1));
  assign in_gnt = (state == GNT0) | (state == GNT1);

  // Counts stalled strobe cycles; any exit from the grant clears it.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (in_gnt && state_nxt == state) begin
      if (s_ack_i || s_err_i)
        cnt <= '0;
      else if (s_stb_o)
        cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // last_gnt = 1 means m1 owned the bus last, so m0 wins a tie.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    unique case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_gnt)) begin
          state_nxt    = GNT0;
          last_gnt_nxt = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt    = GNT1;
          last_gnt_nxt = 1'b1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i)
          state_nxt = IDLE;
`ifdef WBM_ARB_TIMEOUT_EN
        else if (to_hit)
          state_nxt = TOUT;
`endif
      end
      GNT1: begin
        if (!m1_cyc_i)
          state_nxt = IDLE;
`ifdef WBM_ARB_TIMEOUT_EN
        else if (to_hit)
          state_nxt = TOUT;
`endif
      end
`ifdef WBM_ARB_TIMEOUT_EN
      TOUT:    state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    gnt_o    = 2'b00;
    to_evt_o = 1'b0;
    unique case (state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i;
        gnt_o    = 2'b01;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i;
        gnt_o    = 2'b10;
      end
`ifdef WBM_ARB_TIMEOUT_EN
      // Bus is dropped; the owner (unchanged last_gnt) sees the error.
      TOUT: begin
        m0_err_o = ~last_gnt;
        m1_err_o = last_gnt;
        gnt_o    = {last_gnt, ~last_gnt};
        to_evt_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wbm_arb2.sv
// tb_wbm_arb2: directed + random stimulus against a cycle model of wbm_arb2.
// Timeout checks follow WBM_ARB_TIMEOUT_EN as the RTL does.
module tb_wbm_arb2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cyc[2];
  logic          stb[2];
  logic          we[2];
  logic [AW-1:0] adr[2];
  logic [DW-1:0] wdat[2];
  logic [SW-1:0] sel[2];
  logic [DW-1:0] s_dat;
  logic          s_ack, s_err;

  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic [1:0]    gnt_o;
  logic          to_evt_o;

  wbm_arb2 #(.AW(AW), .DW(DW), .TO_CYCLES(TO)) dut (
    .sys_clk(clk), .rst_n(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_adr_i(adr[0]),
    .m0_we_i(we[0]), .m0_dat_i(wdat[0]), .m0_sel_i(sel[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_adr_i(adr[1]),
    .m1_we_i(we[1]), .m1_dat_i(wdat[1]), .m1_sel_i(sel[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .gnt_o(gnt_o), .to_evt_o(to_evt_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: owner -1 = bus free, else index of granted master.
  int m_owner, m_last, m_cnt;
  bit m_tout;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_cnt   = 0;
    m_tout  = 1'b0;
  endtask

  task automatic model_next();
    if (m_tout) begin
      m_tout  = 1'b0;
      m_owner = -1;
    end else if (m_owner < 0) begin
      if (cyc[0] || cyc[1]) begin
        if (cyc[0] && cyc[1]) m_owner = 1 - m_last;
        else m_owner = cyc[0] ? 0 : 1;
        m_last = m_owner;
        m_cnt  = 0;
      end
    end else if (!cyc[m_owner]) begin
      m_owner = -1;
      m_cnt   = 0;
    end else begin
`ifdef WBM_ARB_TIMEOUT_EN
      if (stb[m_owner] && !s_ack && !s_err) begin
        if (m_cnt == TO - 1) begin
          m_tout  = 1'b1;
          m_owner = -1;
          m_cnt   = 0;
        end else begin
          m_cnt++;
        end
      end else if (s_ack || s_err) begin
        m_cnt = 0;
      end
`endif
    end
  endtask

  logic [1:0]    o_gnt;
  logic          o_stb, o_ack0, o_ack1, o_err0, o_err1, o_evt;
  logic [DW-1:0] o_dat1, o_wdat;
  logic [AW-1:0] o_adr;
  int acc_ack0, acc_ack1, acc_err0, acc_evt;

  task automatic zero_acc();
    acc_ack0 = 0;
    acc_ack1 = 0;
    acc_err0 = 0;
    acc_evt  = 0;
  endtask

  task automatic clear_in();
    for (int i = 0; i < 2; i++) begin
      cyc[i]  = 1'b0;
      stb[i]  = 1'b0;
      we[i]   = 1'b0;
      adr[i]  = '0;
      wdat[i] = '0;
      sel[i]  = '0;
    end
    s_dat = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
  endtask

  // One clock: compare at negedge, advance model, return at posedge+1.
  task automatic step();
    logic [1:0]    eg, eack, eerr;
    logic          ec, es, ew, eev;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [SW-1:0] esl;
    @(negedge clk);
    eg = '0; eack = '0; eerr = '0;
    ec = 1'b0; es = 1'b0; ew = 1'b0; eev = 1'b0;
    ea = '0; ed = '0; esl = '0;
    if (m_tout) begin
      eg[m_last]   = 1'b1;
      eerr[m_last] = 1'b1;
      eev          = 1'b1;
    end else if (m_owner >= 0) begin
      eg[m_owner]   = 1'b1;
      ec            = cyc[m_owner];
      es            = stb[m_owner];
      ew            = we[m_owner];
      ea            = adr[m_owner];
      ed            = wdat[m_owner];
      esl           = sel[m_owner];
      eack[m_owner] = s_ack;
      eerr[m_owner] = s_err;
    end
    o_gnt  = gnt_o;
    o_stb  = s_stb_o;
    o_ack0 = m0_ack_o;
    o_ack1 = m1_ack_o;
    o_err0 = m0_err_o;
    o_err1 = m1_err_o;
    o_evt  = to_evt_o;
    o_dat1 = m1_dat_o;
    o_adr  = s_adr_o;
    o_wdat = s_dat_o;
    acc_ack0 += int'(m0_ack_o);
    acc_ack1 += int'(m1_ack_o);
    acc_err0 += int'(m0_err_o);
    acc_evt  += int'(to_evt_o);
    chk("gnt", gnt_o, eg);
    chk("ctl", {s_cyc_o, s_stb_o, s_we_o}, {ec, es, ew});
    chk("adr", s_adr_o, ea);
    chk("wdat", s_dat_o, ed);
    chk("sel", s_sel_o, esl);
    chk("ack", {m1_ack_o, m0_ack_o}, eack);
    chk("err", {m1_err_o, m0_err_o}, eerr);
    chk("rdat0", m0_dat_o, s_dat);
    chk("rdat1", m1_dat_o, s_dat);
    chk("evt", to_evt_o, eev);
    if (!rst_n) model_reset();
    else model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    clear_in();
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [DW-1:0] rd[4];
  int nrd, m0_seen, stb_before, evt_at;
  logic evt_stb, evt_err;
  logic [1:0] gnt_after;

  initial begin
    rst_n = 1'b0;
    clear_in();
    model_reset();
    step();
    step();
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_cyc", s_cyc_o, 1'b0);
    rst_n = 1'b1;

    // m0 single write, ack after 3 cycles
    zero_acc();
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
    adr[0] = 32'h3000_0010; wdat[0] = 32'hA5A5_5A5A; sel[0] = 4'hF;
    step();
    chk("s1_lat", o_gnt, 2'b00);
    step();
    chk("s1_gnt", o_gnt, 2'b01);
    chk("s1_adr", o_adr, 32'h3000_0010);
    chk("s1_dat", o_wdat, 32'hA5A5_5A5A);
    step();
    s_ack = 1'b1;
    step();
    s_ack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    step();
    step();
    chk("s1_idle", o_gnt, 2'b00);
    chk("s1_ack0", acc_ack0, 1);
    chk("s1_ack1", acc_ack1, 0);

    // simultaneous requests and alternation
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
    step();
    step();
    chk("s2_first", o_gnt, 2'b01);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    step();
    step();
    chk("s2_gap", o_gnt, 2'b00);
    step();
    chk("s2_second", o_gnt, 2'b10);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    step();
    step();
    cyc[0] = 1'b1; stb[0] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
    step();
    step();
    chk("s2_alt", o_gnt, 2'b01);

    // m1 burst of 4 reads while m0 waits
    clear_in();
    step();
    step();
    cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h0000_0100;
    step();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    nrd = 0; m0_seen = 0;
    for (int k = 0; k < 4; k++) begin
      s_ack = 1'b1;
      s_dat = 32'h11 * (k + 1);
      step();
      if (o_gnt == 2'b01) m0_seen++;
      if (o_ack1 && nrd < 4) begin
        rd[nrd] = o_dat1;
        nrd++;
      end
    end
    s_ack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    step();
    if (o_gnt == 2'b01) m0_seen++;
    chk("s3_hold", m0_seen, 0);
    step();
    chk("s3_gap", o_gnt, 2'b00);
    step();
    chk("s3_m0", o_gnt, 2'b01);
    chk("s3_nrd", nrd, 4);
    chk("s3_rd0", rd[0], 32'h11);
    chk("s3_rd1", rd[1], 32'h22);
    chk("s3_rd2", rd[2], 32'h33);
    chk("s3_rd3", rd[3], 32'h44);

    // slave error on m0 read
    we[0] = 1'b0; s_err = 1'b1; s_dat = 32'hDEAD_BEEF;
    step();
    chk("s4_err0", o_err0, 1'b1);
    chk("s4_err1", o_err1, 1'b0);
    s_err = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    step();
    step();
    chk("s4_rel", o_gnt, 2'b00);

    // slave never answers
    zero_acc();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    stb_before = 0; evt_at = -1;
    evt_stb = 1'b1; evt_err = 1'b0; gnt_after = 2'b11;
    for (int i = 0; i < 14; i++) begin
      step();
      if (o_evt && evt_at < 0) begin
        evt_at  = i;
        evt_stb = o_stb;
        evt_err = o_err0;
      end else if (evt_at < 0 && o_stb) begin
        stb_before++;
      end
      if (evt_at >= 0 && i == evt_at + 1) gnt_after = o_gnt;
    end
`ifdef WBM_ARB_TIMEOUT_EN
    chk("s5_evts", acc_evt, 1);
    chk("s5_errs", acc_err0, 1);
    chk("s5_stbs", stb_before, TO);
    chk("s5_err", evt_err, 1'b1);
    chk("s5_stb", evt_stb, 1'b0);
    chk("s5_next", gnt_after, 2'b00);
`else
    chk("s5_evts", acc_evt, 0);
    chk("s5_errs", acc_err0, 0);
    chk("s5_hold", o_gnt, 2'b01);
`endif
    clear_in();
    step();
    step();

    // asynchronous reset while m1 owns the bus
    cyc[1] = 1'b1; stb[1] = 1'b1;
    step();
    step();
    chk("s6_gnt", o_gnt, 2'b10);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("s6_cyc", s_cyc_o, 1'b0);
    chk("s6_stb", s_stb_o, 1'b0);
    chk("s6_gnt0", gnt_o, 2'b00);
    clear_in();
    step();
    rst_n = 1'b1;
    cyc[0] = 1'b1; stb[0] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
    step();
    step();
    chk("s6_m0", o_gnt, 2'b01);
    clear_in();
    step();
    step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(3) == 0) cyc[i] = ~cyc[i];
        stb[i]  = cyc[i] & 1'($urandom_range(1));
        we[i]   = 1'($urandom_range(1));
        adr[i]  = $urandom;
        wdat[i] = $urandom;
        sel[i]  = SW'($urandom_range(15));
      end
      s_ack = ($urandom_range(2) == 0);
      s_err = ($urandom_range(9) == 0);
      s_dat = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
